// File: rtl/async_chan_rx_if.sv
// rtl/async_chan_rx_if.sv - bundled-data channel and valid/ready stream bundle for async_chan_rx.
interface async_chan_rx_if #(
   parameter int W     = 15,
   parameter int DEPTH = 4
);
   logic                     ch_req;
   logic [W-1:0]             ch_data;
   logic                     ch_ack;
   logic                     out_valid;
   logic [W-1:0]             out_data;
   logic                     out_ready;
   logic [$clog2(DEPTH):0]   level;

   modport slave (
      input  ch_req, ch_data, out_ready,
      output ch_ack, out_valid, out_data, level
   );

   modport master (
      output ch_req, ch_data, out_ready,
      input  ch_ack, out_valid, out_data, level
   );
endinterface

// File: rtl/async_chan_rx.sv
// rtl/async_chan_rx.sv - clocked receiver for the req/ack bundled-data channel with FIFO output.
// Define ASYNC_RX_TWO_PHASE_EN for 2-phase (transition) signalling; default is 4-phase.
module async_chan_rx #(
   parameter int W           = 15,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   async_chan_rx_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_ack;
   logic                   r_push;
   logic [W-1:0]           r_cap;
   logic [W-1:0]           r_mem [DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [AW:0]            r_level;

   logic                   w_req_s;
   logic                   w_can_push;
   logic                   w_pop;

   assign w_req_s    = r_sync[SYNC_STAGES-1];
   assign w_can_push = (r_level < (AW+1)'(DEPTH));
   assign w_pop      = (r_level != '0) && bus.out_ready;

   assign bus.ch_ack    = r_ack;
   assign bus.out_valid = (r_level != '0);
   assign bus.out_data  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
   assign bus.level     = r_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ch_req};
      end
   end

   // The captured word lands in the FIFO one edge after ack, so out_valid trails ack by a cycle.
`ifdef ASYNC_RX_TWO_PHASE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack  <= 1'b0;
         r_push <= 1'b0;
         r_cap  <= '0;
      end else begin
         r_push <= 1'b0;
         if ((w_req_s != r_ack) && w_can_push) begin
            r_cap  <= bus.ch_data;
            r_push <= 1'b1;
            r_ack  <= ~r_ack;
         end
      end
   end
`else
   typedef enum logic {S_IDLE, S_HOLD} state_t;
   state_t r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_push  <= 1'b0;
         r_cap   <= '0;
      end else begin
         r_push <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req_s && w_can_push) begin
                  r_cap   <= bus.ch_data;
                  r_push  <= 1'b1;
                  r_ack   <= 1'b1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!w_req_s) begin
                  r_ack   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (r_push) begin
         r_mem[r_wr_ptr] <= r_cap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (r_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({r_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end
endmodule

// File: tb/tb_async_chan_rx.sv
// tb/tb_async_chan_rx.sv - directed/random bench for async_chan_rx against a token-queue model.
module tb_async_chan_rx;
   localparam int W           = 15;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;

   logic clk;
   logic rst_n;

   async_chan_rx_if #(.W(W), .DEPTH(DEPTH)) bus ();

   async_chan_rx #(.W(W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic        req_lvl;
   logic        tog_en;
   logic        prev_ack;
   logic [31:0] prev_level;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Consumer side: a word is taken on the edge following a negedge with valid && ready.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
         check("level_bound", 32'(bus.level <= DEPTH), 1);
`ifdef ASYNC_RX_TWO_PHASE_EN
         if (bus.ch_ack !== prev_ack) check("push_gate", 32'(prev_level < DEPTH), 1);
`else
         if (bus.ch_ack && !prev_ack) check("push_gate", 32'(prev_level < DEPTH), 1);
`endif
      end
      prev_ack   = bus.ch_ack;
      prev_level = 32'(bus.level);
   end

   task automatic wait_ack(input logic target, input int budget, output int lat, output logic ok);
      lat = 0;
      ok  = 1'b0;
      while (lat < budget && !ok) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.ch_ack === target) ok = 1'b1;
      end
   endtask

   task automatic req_edge(input logic [W-1:0] d, input int budget, output int lat, output logic ok);
`ifdef ASYNC_RX_TWO_PHASE_EN
      req_lvl = ~req_lvl;
`else
      req_lvl = 1'b1;
`endif
      bus.ch_data = d;
      bus.ch_req  = req_lvl;
      exp_q.push_back(d);
      wait_ack(req_lvl, budget, lat, ok);
   endtask

   task automatic req_finish();
`ifndef ASYNC_RX_TWO_PHASE_EN
      int   lat;
      logic ok;
      req_lvl    = 1'b0;
      bus.ch_req = 1'b0;
      wait_ack(1'b0, 20, lat, ok);
      check("ack_fall_ok", 32'(ok), 1);
      check("ack_fall_lat", lat, SYNC_STAGES + 1);
`endif
   endtask

   task automatic send(input logic [W-1:0] d, input bit chk_lat);
      int   lat;
      logic ok;
      req_edge(d, 40, lat, ok);
      check("ack_ok", 32'(ok), 1);
      if (chk_lat) check("ack_lat", lat, SYNC_STAGES + 1);
      req_finish();
   endtask

   task automatic drain_compare(input string tag);
      int n;
      bus.out_ready = 1'b1;
      n = 0;
      while (bus.level != 0 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_drained"}, 32'(bus.level), 0);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      int   lat;
      logic ok;
      logic [W-1:0] d;

      rst_n         = 1'b0;
      req_lvl       = 1'b1;
      bus.ch_req    = 1'b1;
      bus.ch_data   = 15'h05A5;
      bus.out_ready = 1'b0;
      tog_en        = 1'b0;
      prev_ack      = 1'b0;
      prev_level    = 0;

      // Reset held with req high: everything stays quiet.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack", 32'(bus.ch_ack), 0);
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_data", 32'(bus.out_data), 0);
      check("rst_level", 32'(bus.level), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back(15'h05A5);
      wait_ack(1'b1, 20, lat, ok);
      check("init_ack_ok", 32'(ok), 1);
      check("init_ack_lat", lat, SYNC_STAGES + 1);
      check("init_valid_at_ack", 32'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check("init_valid", 32'(bus.out_valid), 1);
      check("init_data", 32'(bus.out_data), 32'h05A5);
      check("init_level", 32'(bus.level), 1);
      req_finish();
      drain_compare("init");

      // Sequence n*(n+1) with the consumer always ready.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) send(W'(i * (i + 1)), 1'b1);
      drain_compare("seq");

      // Back-pressure: four fill the FIFO, the fifth waits for a pop.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(W'($urandom), 1'b1);
      @(posedge clk);
      #1;
      check("bp_full", 32'(bus.level), DEPTH);
      req_edge(W'($urandom), 12, lat, ok);
      check("bp_no_ack", 32'(ok), 0);
      check("bp_level_hold", 32'(bus.level), DEPTH);
      bus.out_ready = 1'b1;
      wait_ack(req_lvl, SYNC_STAGES + 2, lat, ok);
      check("bp_ack_after_pop", 32'(ok), 1);
      req_finish();
      send(W'($urandom), 1'b1);
      drain_compare("bp");

      // Ready toggling against a full FIFO; 14 words wrap the pointers several laps.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(W'($urandom), 1'b1);
      @(posedge clk);
      #1;
      check("tog_full", 32'(bus.level), DEPTH);
      tog_en = 1'b1;
      fork
         begin
            while (tog_en) begin
               @(posedge clk);
               #2;
               if (tog_en) bus.out_ready = ~bus.out_ready;
            end
         end
      join_none
      for (int i = 0; i < 10; i++) send(W'($urandom), 1'b0);
      tog_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      drain_compare("tog");

      // Reset pulse in the middle of a handshake with two words buffered.
      bus.out_ready = 1'b0;
      send(W'($urandom), 1'b1);
      req_edge(W'($urandom), 20, lat, ok);
      check("hold_ack_ok", 32'(ok), 1);
      @(posedge clk);
      #1;
      check("hold_level", 32'(bus.level), 2);
      check("hold_ack", 32'(bus.ch_ack), 1);
      #2;
      rst_n      = 1'b0;
      req_lvl    = 1'b0;
      bus.ch_req = 1'b0;
      #1;
      check("arst_ack", 32'(bus.ch_ack), 0);
      check("arst_level", 32'(bus.level), 0);
      check("arst_valid", 32'(bus.out_valid), 0);
      exp_q.delete();
      got_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(15'h1234, 1'b1);
      drain_compare("post_rst");

`ifdef ASYNC_RX_TWO_PHASE_EN
      begin
         int   toggles;
         logic last_ack;
         toggles  = 0;
         last_ack = bus.ch_ack;
         for (int i = 1; i <= 5; i++) begin
            req_edge(W'(i), 20, lat, ok);
            check("tp_ack_ok", 32'(ok), 1);
            check("tp_ack_lat", lat, SYNC_STAGES + 1);
            if (bus.ch_ack !== last_ack) toggles++;
            last_ack = bus.ch_ack;
         end
         check("tp_toggles", toggles, 5);
         check("tp_final_ack", 32'(bus.ch_ack), 32'(req_lvl));
         drain_compare("tp");
      end
`endif

      // Random data with a random consumer.
      for (int i = 0; i < 8; i++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         d = W'($urandom);
         send(d, 1'b0);
      end
      drain_compare("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
